// File: rtl/vape_immutability_mr.sv
// Registered VAPE immutability monitor: tracks exec validity against protected
// regions and keeps first-violation diagnostics with a saturating count.
module vape_rgn_hit #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    input  logic              en,
    output logic              hit
);
    // An inverted range (lo > hi) can never satisfy both bounds.
    assign hit = en && (addr >= lo) && (addr <= hi);
endmodule

module vape_immutability_mr #(
    parameter int                ADDR_W    = 16,
    parameter int                N_REGIONS = 4,
    parameter logic [ADDR_W-1:0] META_MIN  = 16'h0140,
    parameter logic [ADDR_W-1:0] META_MAX  = 16'h016A,
    parameter logic [ADDR_W-1:0] IVT_MIN   = 16'hFFE0,
    parameter logic [ADDR_W-1:0] IVT_MAX   = 16'hFFFF,
    parameter int                CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             pc,
    input  logic [ADDR_W-1:0]             data_addr,
    input  logic                          data_en,
    input  logic [ADDR_W-1:0]             dma_addr,
    input  logic                          dma_en,
    input  logic [ADDR_W-1:0]             ER_min,
    input  logic [ADDR_W-1:0]             ER_max,
    input  logic [N_REGIONS*ADDR_W-1:0]   rgn_min,
    input  logic [N_REGIONS*ADDR_W-1:0]   rgn_max,
    input  logic [N_REGIONS-1:0]          rgn_en,
    input  logic                          clr,
    output logic                          exec,
    output logic                          viol_valid,
    output logic [1:0]                    viol_src,
    output logic [ADDR_W-1:0]             viol_addr,
    output logic [N_REGIONS+2:0]          viol_rgn,
    output logic [CNT_W-1:0]              viol_cnt
);
    localparam int NR = N_REGIONS + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {ABORT = 1'b0, EXEC = 1'b1} state_t;
    state_t state;

    logic [NR-1:0][ADDR_W-1:0] lo_all, hi_all;
    logic [NR-1:0]             en_all;
    logic [NR-1:0]             cpu_raw, dma_raw, cpu_mask, dma_mask, new_rgn;
    logic                      hit_cpu, hit_dma, mem_change, is_fst_er;
    logic [ADDR_W-1:0]         cap_addr;

    always_comb begin
        lo_all[0] = ER_min;   hi_all[0] = ER_max;
        lo_all[1] = META_MIN; hi_all[1] = META_MAX;
        lo_all[2] = IVT_MIN;  hi_all[2] = IVT_MAX;
        for (int i = 0; i < N_REGIONS; i++) begin
            lo_all[i+3] = rgn_min[i*ADDR_W +: ADDR_W];
            hi_all[i+3] = rgn_max[i*ADDR_W +: ADDR_W];
        end
        en_all = {rgn_en, 3'b111};
    end

    for (genvar g = 0; g < NR; g++) begin : g_rgn
        vape_rgn_hit #(.ADDR_W(ADDR_W)) u_cpu (
            .addr(data_addr), .lo(lo_all[g]), .hi(hi_all[g]), .en(en_all[g]), .hit(cpu_raw[g])
        );
        vape_rgn_hit #(.ADDR_W(ADDR_W)) u_dma (
            .addr(dma_addr), .lo(lo_all[g]), .hi(hi_all[g]), .en(en_all[g]), .hit(dma_raw[g])
        );
    end

    assign cpu_mask   = data_en ? cpu_raw : '0;
    assign dma_mask   = dma_en ? dma_raw : '0;
    assign new_rgn    = cpu_mask | dma_mask;
    assign hit_cpu    = |cpu_mask;
    assign hit_dma    = |dma_mask;
    assign mem_change = hit_cpu | hit_dma;
    assign is_fst_er  = (pc == ER_min);
    assign cap_addr   = hit_cpu ? data_addr : dma_addr;

    // While in reset the state register may still hold EXEC; exec must already
    // behave as if in ABORT.
    assign exec = ((rst_n && state == EXEC) || is_fst_er) && !mem_change;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ABORT;
            viol_valid <= 1'b0;
            viol_src   <= '0;
            viol_addr  <= '0;
            viol_rgn   <= '0;
            viol_cnt   <= '0;
        end else begin
            case (state)
                ABORT:   if (is_fst_er && !mem_change) state <= EXEC;
                EXEC:    if (mem_change) state <= ABORT;
                default: state <= ABORT;
            endcase

            if (mem_change) begin
                if (clr || !viol_valid) begin
                    viol_addr  <= cap_addr;
                    viol_valid <= 1'b1;
                end
                // A violation in the clearing cycle restarts the record from it.
                if (clr) begin
                    viol_src <= {hit_dma, hit_cpu};
                    viol_rgn <= new_rgn;
                    viol_cnt <= CNT_W'(1);
                end else begin
                    viol_src <= viol_src | {hit_dma, hit_cpu};
                    viol_rgn <= viol_rgn | new_rgn;
                    viol_cnt <= (viol_cnt == CNT_MAX) ? viol_cnt : viol_cnt + 1'b1;
                end
            end else if (clr) begin
                viol_valid <= 1'b0;
                viol_src   <= '0;
                viol_addr  <= '0;
                viol_rgn   <= '0;
                viol_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vape_immutability_mr.sv
// Bench for vape_immutability_mr: directed literal checks plus randomized
// stimulus compared each cycle against a behavioural model.
module tb_vape_immutability_mr;
    localparam int NRG = 4;
    localparam int NR  = NRG + 3;

    logic clk = 0, rst_n = 0;
    logic [15:0] pc = 0, data_addr = 0, dma_addr = 0, ER_min = 16'hE000, ER_max = 16'hE0FF;
    logic data_en = 0, dma_en = 0, clr = 0;
    logic [NRG*16-1:0] rgn_min = '0, rgn_max = '0;
    logic [NRG-1:0] rgn_en = '0;

    logic exec, viol_valid, exec2, viol_valid2;
    logic [1:0] viol_src, viol_src2;
    logic [15:0] viol_addr, viol_addr2;
    logic [NR-1:0] viol_rgn, viol_rgn2;
    logic [7:0] viol_cnt;
    logic [1:0] viol_cnt2;

    vape_immutability_mr dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .data_addr(data_addr), .data_en(data_en),
        .dma_addr(dma_addr), .dma_en(dma_en), .ER_min(ER_min), .ER_max(ER_max),
        .rgn_min(rgn_min), .rgn_max(rgn_max), .rgn_en(rgn_en), .clr(clr),
        .exec(exec), .viol_valid(viol_valid), .viol_src(viol_src), .viol_addr(viol_addr),
        .viol_rgn(viol_rgn), .viol_cnt(viol_cnt)
    );

    vape_immutability_mr #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .pc(pc), .data_addr(data_addr), .data_en(data_en),
        .dma_addr(dma_addr), .dma_en(dma_en), .ER_min(ER_min), .ER_max(ER_max),
        .rgn_min(rgn_min), .rgn_max(rgn_max), .rgn_en(rgn_en), .clr(clr),
        .exec(exec2), .viol_valid(viol_valid2), .viol_src(viol_src2), .viol_addr(viol_addr2),
        .viol_rgn(viol_rgn2), .viol_cnt(viol_cnt2)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_exec_st = 0, m_valid = 0, go = 0;
    bit [1:0]   m_src = 0;
    bit [15:0]  m_addr = 0;
    bit [NR-1:0] m_rgn = 0;
    int         m_n = 0;   // unbounded violation count since last clear

    function automatic bit [NR-1:0] hits(input bit [15:0] a);
        bit [NR-1:0] m;
        int lo, hi;
        m[0] = (a >= ER_min) && (a <= ER_max);
        m[1] = (a >= 16'h0140) && (a <= 16'h016A);
        m[2] = (a >= 16'hFFE0);
        for (int i = 0; i < NRG; i++) begin
            lo = int'(rgn_min[i*16 +: 16]);
            hi = int'(rgn_max[i*16 +: 16]);
            m[i+3] = rgn_en[i] && (int'(a) >= lo) && (int'(a) <= hi);
        end
        return m;
    endfunction

    function automatic bit [NR-1:0] cpu_m(); return data_en ? hits(data_addr) : '0; endfunction
    function automatic bit [NR-1:0] dma_m(); return dma_en ? hits(dma_addr) : '0; endfunction

    function automatic bit model_exec();
        bit mc = |(cpu_m() | dma_m());
        bit fst = (pc == ER_min);
        if (!rst_n || !m_exec_st) return fst && !mc;
        return !mc;
    endfunction

    function automatic int sat(input int n, input int w);
        int mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    always @(posedge clk) begin
        bit [NR-1:0] cm, dm;
        bit mc, fst;
        cm = cpu_m(); dm = dma_m();
        mc = |(cm | dm);
        fst = (pc == ER_min);
        if (!rst_n) begin
            m_exec_st = 0; m_valid = 0; m_src = 0; m_addr = 0; m_rgn = 0; m_n = 0;
        end else begin
            if (m_exec_st) m_exec_st = !mc;
            else           m_exec_st = fst && !mc;
            if (clr) begin
                m_valid = 0; m_src = 0; m_addr = 0; m_rgn = 0; m_n = 0;
            end
            if (mc) begin
                if (!m_valid) m_addr = (|cm) ? data_addr : dma_addr;
                m_valid = 1;
                m_src = m_src | {|dm, |cm};
                m_rgn = m_rgn | cm | dm;
                m_n++;
            end
        end
        go = 1;
    end

    always @(negedge clk) if (go) begin
        chk("exec", 32'(exec), 32'(model_exec()));
        chk("exec2", 32'(exec2), 32'(model_exec()));
        chk("viol_valid", 32'(viol_valid), 32'(m_valid));
        chk("viol_src", 32'(viol_src), 32'(m_src));
        chk("viol_addr", 32'(viol_addr), 32'(m_addr));
        chk("viol_rgn", 32'(viol_rgn), 32'(m_rgn));
        chk("viol_cnt", 32'(viol_cnt), 32'(sat(m_n, 8)));
        chk("viol_cnt2", 32'(viol_cnt2), 32'(sat(m_n, 2)));
    end

    // ---------------- stimulus ----------------
    task automatic tick(); @(posedge clk); #1; endtask

    task automatic idle(input logic [15:0] p);
        pc = p; data_en = 0; dma_en = 0; clr = 0;
    endtask

    function automatic logic [15:0] rnd_addr();
        case ($urandom_range(0, 5))
            0: return ER_min + 16'($urandom_range(0, 300));
            1: return 16'h0130 + 16'($urandom_range(0, 64));
            2: return 16'hFFD0 + 16'($urandom_range(0, 47));
            3: return 16'h2000 + 16'($urandom_range(0, 16'h5000));
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        // reset
        tick(); tick();
        chk("rst_valid", 32'(viol_valid), 32'h0);
        chk("rst_cnt", 32'(viol_cnt), 32'h0);
        rst_n = 1;

        // entry into EXEC
        idle(16'hE000); #1 chk("fst_exec", 32'(exec), 32'h1);
        tick(); idle(16'hE010); #1 chk("exec_hold", 32'(exec), 32'h1);

        // CPU write into ER
        data_addr = 16'hE050; data_en = 1; #1 chk("viol_exec0", 32'(exec), 32'h0);
        tick(); idle(16'hE010); #1;
        chk("d1_exec", 32'(exec), 32'h0);
        chk("d1_valid", 32'(viol_valid), 32'h1);
        chk("d1_src", 32'(viol_src), 32'h1);
        chk("d1_addr", 32'(viol_addr), 32'hE050);
        chk("d1_rgn", 32'(viol_rgn), 32'h01);
        chk("d1_cnt", 32'(viol_cnt), 32'h1);
        pc = 16'hE000; #1 chk("d1_reenter", 32'(exec), 32'h1);
        tick(); clr = 1; tick(); clr = 0; #1;
        chk("clr_valid", 32'(viol_valid), 32'h0);
        chk("clr_rgn", 32'(viol_rgn), 32'h0);

        // simultaneous CPU+DMA
        data_addr = 16'h0150; data_en = 1; dma_addr = 16'hFFF0; dma_en = 1;
        tick(); idle(16'hE000); #1;
        chk("d2_src", 32'(viol_src), 32'h3);
        chk("d2_addr", 32'(viol_addr), 32'h0150);
        chk("d2_rgn", 32'(viol_rgn), 32'h6);

        // extra regions
        tick(); pc = 16'hE010;
        rgn_min[15:0] = 16'h2000; rgn_max[15:0] = 16'h20FF;
        rgn_min[31:16] = 16'h3000; rgn_max[31:16] = 16'h2000; rgn_en = 4'b0010;
        data_addr = 16'h2080; data_en = 1; #1 chk("r0_dis", 32'(exec), 32'h1);
        tick(); rgn_en = 4'b0011; #1 chk("r0_en", 32'(exec), 32'h0);
        tick(); idle(16'hE010); #1;
        chk("r0_rgn", 32'(viol_rgn), 32'h0E);
        chk("r0_cnt", 32'(viol_cnt), 32'h2);
        chk("r0_addr", 32'(viol_addr), 32'h0150);
        pc = 16'hE000; tick(); pc = 16'hE010;
        data_addr = 16'h3000; data_en = 1; #1 chk("inv_3000", 32'(exec), 32'h1);
        tick(); data_addr = 16'h2000; rgn_en = 4'b0010; #1 chk("inv_2000", 32'(exec), 32'h1);

        // clear racing a violation, then saturation
        tick(); data_addr = 16'hE001; clr = 1;
        tick(); clr = 0; data_en = 0; #1;
        chk("cv_cnt", 32'(viol_cnt), 32'h1);
        chk("cv_addr", 32'(viol_addr), 32'hE001);
        chk("cv_rgn", 32'(viol_rgn), 32'h1);
        data_en = 1;
        for (int i = 2; i <= 5; i++) begin
            data_addr = 16'hE000 + 16'(i); tick();
        end
        data_en = 0; #1;
        chk("sat_cnt8", 32'(viol_cnt), 32'h5);
        chk("sat_cnt2", 32'(viol_cnt2), 32'h3);
        chk("sat_addr", 32'(viol_addr2), 32'hE001);
        clr = 1; tick(); clr = 0; #1;
        chk("clr2_cnt", 32'(viol_cnt), 32'h0);
        chk("clr2_addr", 32'(viol_addr), 32'h0);
        chk("clr2_src", 32'(viol_src), 32'h0);

        // reset mid-EXEC
        idle(16'hE000); tick(); pc = 16'hE010; #1 chk("pre_rst", 32'(exec), 32'h1);
        rst_n = 0; #1 chk("in_rst", 32'(exec), 32'h0);
        tick(); rst_n = 1; #1 chk("post_rst", 32'(exec), 32'h0);

        // randomized phase
        for (int c = 0; c < 2000; c++) begin
            tick();
            if ($urandom_range(0, 49) == 0) begin
                ER_min = ($urandom_range(0, 1) != 0) ? 16'hE000 : 16'hC000;
                ER_max = ER_min + 16'($urandom_range(0, 511));
                for (int i = 0; i < NRG; i++) begin
                    int lo = 16'h1000 * (i + 2) + $urandom_range(0, 255);
                    rgn_min[i*16 +: 16] = 16'(lo);
                    rgn_max[i*16 +: 16] = 16'(lo + $urandom_range(0, 1023) - 256);
                end
                rgn_en = 4'($urandom());
            end
            pc        = ($urandom_range(0, 1) != 0) ? ER_min : rnd_addr();
            data_addr = rnd_addr();
            dma_addr  = rnd_addr();
            data_en   = ($urandom_range(0, 3) == 0);
            dma_en    = ($urandom_range(0, 4) == 0);
            clr       = ($urandom_range(0, 15) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
        end
        tick(); rst_n = 1;
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vape_immutability_mr.md
# vape_immutability_mr

Parametrised, registered successor to the VAPE immutability monitor. It watches CPU and DMA write buses against the executable region (ER), the metadata and IVT regions, and up to N_REGIONS software-configurable extra regions. It drives the `exec` flag consumed by the attestation logic. It also records diagnostic evidence of the first violation since the last clear: source, address and regions hit, plus a saturating violation count.

## Interface
- `ADDR_W`, 16: address width.
- `N_REGIONS`, 4: extra protected regions (1..8).
- `META_MIN`, 16'h0140: metadata lower bound, inclusive.
- `META_MAX`, 16'h016A: metadata upper bound, inclusive.
- `IVT_MIN`, 16'hFFE0: IVT lower bound, inclusive.
- `IVT_MAX`, 16'hFFFF: IVT upper bound, inclusive.
- `CNT_W`, 8: violation counter width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `pc` in ADDR_W: current program counter.
- `data_addr` in ADDR_W: CPU write address.
- `data_en` in 1: CPU write strobe.
- `dma_addr` in ADDR_W: DMA address.
- `dma_en` in 1: DMA write strobe.
- `ER_min`, `ER_max` in ADDR_W each: ER bounds, inclusive.
- `rgn_min`, `rgn_max` in N_REGIONS*ADDR_W each: extra region bounds; region i occupies bits [i*ADDR_W +: ADDR_W].
- `rgn_en` in N_REGIONS: per-region enable.
- `clr` in 1: clears diagnostic registers; has no effect on the state machine.
- `exec` out 1: execution-valid flag.
- `viol_valid` out 1: a violation has been captured since the last reset or clear.
- `viol_src` out 2: bit0 = CPU, bit1 = DMA; sticky.
- `viol_addr` out ADDR_W: address of the first captured violation.
- `viol_rgn` out N_REGIONS+3: sticky hit mask; bit0 = ER, bit1 = META, bit2 = IVT, bit3+i = extra region i.
- `viol_cnt` out CNT_W: number of cycles with a violation; saturates.

## Operation
- Region hit: `lo <= addr <= hi`, unsigned compare.
  - A region with lo > hi never matches.
  - A disabled extra region never matches.
- `hit_cpu`: `data_en` is high and `data_addr` hits any region. `hit_dma`: `dma_en` is high and `dma_addr` hits any region. `mem_change = hit_cpu | hit_dma`.
- `is_fst_ER = (pc == ER_min)`.
- State register, 1 bit: ABORT (reset value) and EXEC.
  - ABORT -> EXEC when `is_fst_ER & !mem_change`.
  - EXEC -> ABORT when `mem_change`.
  - Otherwise the state holds.
- `exec` is combinational from the registered state and the current inputs:
  - in EXEC: `exec = !mem_change`;
  - in ABORT: `exec = is_fst_ER & !mem_change`.
  - A violating cycle therefore deasserts `exec` in that same cycle.
- Diagnostics update on every cycle with `mem_change`:
  - `viol_src` ORs in {hit_dma, hit_cpu}.
  - `viol_rgn` ORs in the union of the CPU and DMA hit masks.
  - `viol_cnt` increments and saturates at 2^CNT_W−1.
  - When `viol_valid` is 0: capture `viol_addr` (`data_addr` if `hit_cpu`, else `dma_addr`) and set `viol_valid`.
- `clr` with no violation in the same cycle: all diagnostics go to 0 next cycle.
- `clr` with a violation in the same cycle: the violation wins. Diagnostics reload with that cycle's values only, `viol_cnt` = 1 and `viol_valid` = 1.
- CPU and DMA violating together: both `viol_src` bits are set; `viol_addr` takes the CPU address.
- ER bounds may change at runtime. Compares always use the current inputs; nothing latches them.

## Timing
- Reset: state = ABORT, `viol_valid` = 0, `viol_src` = 0, `viol_addr` = 0, `viol_rgn` = 0, `viol_cnt` = 0.
  - `exec` equals `is_fst_ER & !mem_change` while `rst_n` is low.
  - Reset asserted mid-EXEC forces ABORT at the next edge.
- State and diagnostic registers have 1-cycle latency. `exec` has 0-cycle latency.
- No handshakes. Every input is sampled every cycle.

## Test plan
- Reset, then `pc`=ER_min=16'hE000, ER_max=16'hE0FF, no writes: `exec`=1 in that cycle and state = EXEC next. Then `pc`=16'hE010: `exec` stays 1.
- In EXEC, CPU writes 16'hE050 (`data_en`=1): `exec`=0 in the same cycle, and after the edge state = ABORT, `viol_valid`=1, `viol_src`=2'b01, `viol_addr`=16'hE050, `viol_rgn` bit0 set, `viol_cnt`=1. `pc`=16'hE010 afterwards: `exec`=0. `pc`=ER_min with no writes: `exec`=1.
- DMA writes 16'hFFF0 while CPU writes 16'h0150 in the same cycle: `viol_src`=2'b11, `viol_addr`=16'h0150, `viol_rgn`=bits1|2.
- Extra region 0 = [16'h2000, 16'h20FF]: write 16'h2080 with `rgn_en[0]`=0 gives no violation; with `rgn_en[0]`=1 it gives a violation and bit3 set. A region with min=16'h3000, max=16'h2000 never hits.
- CNT_W=2 with 5 violating cycles: `viol_cnt`=3. `viol_addr` keeps the first address.
- `clr` and a violation at 16'hE001 in the same cycle: `viol_cnt`=1, `viol_addr`=16'hE001. `clr` alone: all diagnostics 0. `rst_n`=0 mid-EXEC: ABORT next cycle.
